axis_frame_router: RTL and testbench

Parametrised, double-buffered sample router between the SPI accelerometer read path and the UART/display consumers. It collects `NUM_AXES` consecutive `DATA_W`-bit samples into a shadow bank. When the last axis of a frame arrives, it commits the whole frame atomically to an output bank, so readers never see a mix of old and new axes. A registered index-selected read port serves the consumer, with a frame-ready handshake and optional overrun detection.

---
 rtl/axis_frame_router.sv | 174 +++++++++++++++++
 tb/tb_axis_frame_router.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_router.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_router
// Description : Double-buffered axis sample router. Collects NUM_AXES
//               consecutive samples into a shadow bank and commits the whole
//               frame atomically to an output bank on the final axis, so the
//               reader never sees a mix of old and new axes. Registered
//               index-selected read port, frame-ready pulse, pending level.
//               Optional sticky overrun detection, enabled by defining the
//               macro AXIS_FRAME_ROUTER_OVERRUN_EN (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_router #(
    parameter int DATA_W   = 16,
    parameter int NUM_AXES = 3,
    parameter int SEL_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              frame_sync,
    input  logic [SEL_W-1:0]  sel,
    input  logic              frame_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              frame_ready,
    output logic              frame_pending,
    output logic [SEL_W-1:0]  slot,
    output logic              overrun
);

    localparam logic [SEL_W-1:0] c_last_slot = SEL_W'(NUM_AXES - 1);
    localparam logic [SEL_W-1:0] c_num_axes  = SEL_W'(NUM_AXES);

    // Shadow only needs the first NUM_AXES-1 axes: the final axis goes
    // straight from data_in into the bank on the commit edge.
    logic [DATA_W-1:0] r_shadow [NUM_AXES-1];
    logic [DATA_W-1:0] r_bank   [NUM_AXES];
    logic [SEL_W-1:0]  r_slot;
    logic              r_have_frame;
    logic              r_frame_ready;
    logic              r_frame_pending;
    logic [DATA_W-1:0] r_data_out;
    logic              r_out_valid;

    logic [SEL_W-1:0]  w_wr_slot;
    logic              w_commit;
    logic [SEL_W-1:0]  w_slot_next;
    logic              w_sel_in_range;
    logic [DATA_W-1:0] w_rd_data;

    // Effective write slot: frame_sync realigns the frame to slot 0 this cycle.
    always_comb begin
        w_wr_slot = frame_sync ? '0 : r_slot;
        w_commit  = load && (w_wr_slot == c_last_slot);
    end

    // Slot counter next value: advance on load, wrap on commit, hold otherwise.
    always_comb begin
        w_slot_next = r_slot;
        if (load) begin
            if (w_commit) begin
                w_slot_next = '0;
            end else begin
                w_slot_next = w_wr_slot + SEL_W'(1);
            end
        end else if (frame_sync) begin
            w_slot_next = '0;
        end
    end

    // Committed-bank read mux; out-of-range selects read as zero.
    always_comb begin
        w_sel_in_range = (sel < c_num_axes);
        w_rd_data      = '0;
        for (int i = 0; i < NUM_AXES; i++) begin
            if (sel == SEL_W'(i)) begin
                w_rd_data = r_bank[i];
            end
        end
    end

    // Slot counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_next;
        end
    end

    // Shadow bank: capture each non-final axis as it arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AXES - 1; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_AXES - 1; i++) begin
                if (w_wr_slot == SEL_W'(i)) begin
                    r_shadow[i] <= data_in;
                end
            end
        end
    end

    // Output bank: whole-frame atomic update on the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AXES; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_AXES - 1; i++) begin
                r_bank[i] <= r_shadow[i];
            end
            r_bank[NUM_AXES-1] <= data_in;
        end
    end

    // Frame status flags: ready pulse, pending level, sticky have-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_ready   <= 1'b0;
            r_frame_pending <= 1'b0;
            r_have_frame    <= 1'b0;
        end else begin
            r_frame_ready <= w_commit;
            if (w_commit) begin
                r_frame_pending <= 1'b1;
                r_have_frame    <= 1'b1;
            end else if (frame_ack) begin
                r_frame_pending <= 1'b0;
            end
        end
    end

    // Registered read port: one cycle from sel, sees bank as of last edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_data_out  <= w_sel_in_range ? w_rd_data : '0;
            r_out_valid <= w_sel_in_range && r_have_frame;
        end
    end

`ifdef AXIS_FRAME_ROUTER_OVERRUN_EN
    logic r_overrun;

    // Sticky overrun: a new frame landed on top of an unacknowledged one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_commit && r_frame_pending && !frame_ack) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

    assign data_out      = r_data_out;
    assign out_valid     = r_out_valid;
    assign frame_ready   = r_frame_ready;
    assign frame_pending = r_frame_pending;
    assign slot          = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_router
// Description : Directed self-checking bench for axis_frame_router
//               (DATA_W=16, NUM_AXES=3, SEL_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic        frame_sync = 1'b0;
    logic [2:0]  sel = '0;
    logic        frame_ack = 1'b0;
    logic [15:0] data_out;
    logic        out_valid;
    logic        frame_ready;
    logic        frame_pending;
    logic [2:0]  slot;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

`ifdef AXIS_FRAME_ROUTER_OVERRUN_EN
    localparam logic c_ovr_exp = 1'b1;
`else
    localparam logic c_ovr_exp = 1'b0;
`endif

    axis_frame_router #(.DATA_W(16), .NUM_AXES(3), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .frame_sync(frame_sync), .sel(sel), .frame_ack(frame_ack),
        .data_out(data_out), .out_valid(out_valid), .frame_ready(frame_ready),
        .frame_pending(frame_pending), .slot(slot), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one sample, then check slot and frame_ready after the edge.
    task automatic load_one(input logic [15:0] v, input logic [2:0] exp_slot,
                            input logic exp_rdy);
        load = 1'b1; data_in = v;
        tick();
        load = 1'b0;
        n_vec++;
        if (slot !== exp_slot) begin
            n_err++; $display("FAIL load_slot v=%h: got %0d want %0d", v, slot, exp_slot);
        end
        n_vec++;
        if (frame_ready !== exp_rdy) begin
            n_err++; $display("FAIL load_ready v=%h: got %b want %b", v, frame_ready, exp_rdy);
        end
    endtask

    // Read one select and compare data_out / out_valid.
    task automatic read_sel(input logic [2:0] s, input logic [15:0] exp_d, input logic exp_v);
        sel = s;
        tick();
        n_vec++;
        if (data_out !== exp_d) begin
            n_err++; $display("FAIL read_data sel=%0d: got %h want %h", s, data_out, exp_d);
        end
        n_vec++;
        if (out_valid !== exp_v) begin
            n_err++; $display("FAIL read_valid sel=%0d: got %b want %b", s, out_valid, exp_v);
        end
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        n_vec++;
        if (frame_pending !== 1'b0) begin
            n_err++; $display("FAIL ack_pending: got %b want 0", frame_pending);
        end
    endtask

    task automatic check_idle_flags(input string tag);
        n_vec++;
        if ({slot, frame_ready, frame_pending, overrun} !== 6'b0) begin
            n_err++;
            $display("FAIL %s_flags: slot=%0d rdy=%b pend=%b ovr=%b want all 0",
                     tag, slot, frame_ready, frame_pending, overrun);
        end
        n_vec++;
        if ({data_out, out_valid} !== 17'b0) begin
            n_err++; $display("FAIL %s_read: data=%h valid=%b want 0/0", tag, data_out, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        check_idle_flags("reset");
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            read_sel(3'(s), 16'h0000, 1'b0);
        end
        check_idle_flags("reset_after_reads");
    endtask

    task automatic test_single_frame();
        load_one(16'h1111, 3'd1, 1'b0);
        load_one(16'h2222, 3'd2, 1'b0);
        load_one(16'h3333, 3'd0, 1'b1);
        n_vec++;
        if (frame_pending !== 1'b1) begin
            n_err++; $display("FAIL single_pending: got %b want 1", frame_pending);
        end
        read_sel(3'd0, 16'h1111, 1'b1);
        n_vec++;
        if (frame_ready !== 1'b0) begin
            n_err++; $display("FAIL single_ready_pulse: got %b want 0", frame_ready);
        end
        read_sel(3'd1, 16'h2222, 1'b1);
        read_sel(3'd2, 16'h3333, 1'b1);
        read_sel(3'd3, 16'h0000, 1'b0);
        read_sel(3'd7, 16'h0000, 1'b0);
        ack_frame();
    endtask

    task automatic test_coherence();
        load_one(16'hA000, 3'd1, 1'b0);
        load_one(16'hA001, 3'd2, 1'b0);
        load_one(16'hA002, 3'd0, 1'b1);
        ack_frame();
        load_one(16'hB000, 3'd1, 1'b0);
        load_one(16'hB001, 3'd2, 1'b0);
        read_sel(3'd0, 16'hA000, 1'b1);
        read_sel(3'd1, 16'hA001, 1'b1);
        read_sel(3'd2, 16'hA002, 1'b1);
        // Held sel shows the new frame only one edge after the commit edge.
        sel = 3'd2;
        load_one(16'hB002, 3'd0, 1'b1);
        n_vec++;
        if (data_out !== 16'hA002) begin
            n_err++; $display("FAIL coherence_commit_edge: got %h want a002", data_out);
        end
        read_sel(3'd2, 16'hB002, 1'b1);
        read_sel(3'd0, 16'hB000, 1'b1);
        read_sel(3'd1, 16'hB001, 1'b1);
        ack_frame();
    endtask

    task automatic test_resync();
        load_one(16'hAAAA, 3'd1, 1'b0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        n_vec++;
        if (slot !== 3'd0) begin
            n_err++; $display("FAIL resync_slot: got %0d want 0", slot);
        end
        load_one(16'h0001, 3'd1, 1'b0);
        load_one(16'h0002, 3'd2, 1'b0);
        load_one(16'h0003, 3'd0, 1'b1);
        read_sel(3'd0, 16'h0001, 1'b1);
        read_sel(3'd1, 16'h0002, 1'b1);
        read_sel(3'd2, 16'h0003, 1'b1);
        ack_frame();
        // frame_sync with load: sample lands in slot 0, counter goes to 1.
        load_one(16'h0E00, 3'd1, 1'b0);
        frame_sync = 1'b1;
        load_one(16'h0F00, 3'd1, 1'b0);
        frame_sync = 1'b0;
        load_one(16'h0F01, 3'd2, 1'b0);
        load_one(16'h0F02, 3'd0, 1'b1);
        read_sel(3'd0, 16'h0F00, 1'b1);
        ack_frame();
    endtask

    task automatic test_overrun();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_one(16'h0101, 3'd1, 1'b0);
        load_one(16'h0102, 3'd2, 1'b0);
        load_one(16'h0103, 3'd0, 1'b1);
        load_one(16'h0201, 3'd1, 1'b0);
        load_one(16'h0202, 3'd2, 1'b0);
        frame_ack = 1'b1;
        load_one(16'h0203, 3'd0, 1'b1);
        frame_ack = 1'b0;
        n_vec++;
        if (frame_pending !== 1'b1) begin
            n_err++; $display("FAIL ovr_ack_pending: got %b want 1", frame_pending);
        end
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++; $display("FAIL ovr_ack_overrun: got %b want 0", overrun);
        end
        load_one(16'h0301, 3'd1, 1'b0);
        load_one(16'h0302, 3'd2, 1'b0);
        load_one(16'h0303, 3'd0, 1'b1);
        n_vec++;
        if (overrun !== c_ovr_exp) begin
            n_err++; $display("FAIL ovr_set: got %b want %b", overrun, c_ovr_exp);
        end
        ack_frame();
        tick(); tick();
        n_vec++;
        if (overrun !== c_ovr_exp) begin
            n_err++; $display("FAIL ovr_sticky: got %b want %b", overrun, c_ovr_exp);
        end
    endtask

    task automatic test_reset_mid_frame();
        sel = 3'd1;
        load_one(16'h5551, 3'd1, 1'b0);
        load_one(16'h5552, 3'd2, 1'b0);
        rst = 1'b1;
        #1;
        check_idle_flags("midreset");
        tick();
        rst = 1'b0;
        read_sel(3'd0, 16'h0000, 1'b0);
        load_one(16'h6661, 3'd1, 1'b0);
        load_one(16'h6662, 3'd2, 1'b0);
        load_one(16'h6663, 3'd0, 1'b1);
        read_sel(3'd0, 16'h6661, 1'b1);
        read_sel(3'd1, 16'h6662, 1'b1);
        read_sel(3'd2, 16'h6663, 1'b1);
    endtask

    task automatic test_back_to_back();
        ack_frame();
        load = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < 3; a++) begin
                data_in = 16'(16'h7000 + f * 16 + a);
                tick();
                n_vec++;
                if (frame_ready !== (a == 2)) begin
                    n_err++;
                    $display("FAIL b2b_ready f=%0d a=%0d: got %b want %b",
                             f, a, frame_ready, (a == 2));
                end
            end
        end
        load = 1'b0;
        read_sel(3'd0, 16'h7020, 1'b1);
        read_sel(3'd2, 16'h7022, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_coherence();
        test_resync();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
